// File: rtl/sram_bist.sv
// sram_bist: built-in self-test sequencer placed in front of an SRAM controller.
// On start it writes an address-derived pattern over addresses 0..ADDR_LAST, reads the
// range back and compares, then repeats with the inverted pattern.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               one-cycle test request (ignored while busy)
//   mem, rw, addr,      request port to the controller (rw: 1 = read, 0 = write)
//   data_f2s
//   ready, data_s2f_r   controller accept strobe and registered read data
//   busy, done, pass    test status
//   err_cnt             saturating mismatch count
//   fail_addr/data/exp  location, read data and expected data of the first mismatch
module sram_bist #(
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_LAST = 2**18 - 1,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem,
  output logic              rw,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_f2s,
  input  logic              ready,
  input  logic [DATA_W-1:0] data_s2f_r,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [DATA_W-1:0] fail_exp
);

  typedef enum logic [2:0] {StIdle, StWr, StRd, StDrain, StDone} state_e;

  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(ADDR_LAST);
  localparam logic [7:0]        DrainLast = 8'(RD_LAT - 1);

  // Low 16 address bits folded with bits 17:16, sized to DATA_W, inverted in phase 1.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a, input logic ph);
    logic [17:0]       a18;
    logic [15:0]       p16;
    logic [DATA_W-1:0] p;
    a18 = 18'(a);
    p16 = a18[15:0] ^ {14'b0, a18[17:16]};
    p   = DATA_W'(p16);
    return ph ? ~p : p;
  endfunction

  state_e              state_q, state_d;
  logic                phase_q, phase_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [7:0]          drain_q, drain_d;
  logic                req_q, req_d;
  logic                rw_q, rw_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [15:0]         err_q, err_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0]   fail_data_q, fail_data_d;
  logic [DATA_W-1:0]   fail_exp_q, fail_exp_d;

  // Read-compare shift pipe; entry RD_LAT-1 lines up with data_s2f_r.
  logic [RD_LAT-1:0]             pv_q, pv_d;
  logic [RD_LAT-1:0][ADDR_W-1:0] pa_q, pa_d;
  logic [RD_LAT-1:0][DATA_W-1:0] pe_q, pe_d;

  logic acc;
  logic push;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    err_d       = err_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    fail_exp_d  = fail_exp_q;
    push        = 1'b0;
    pv_d        = '0;
    pa_d        = '0;
    pe_d        = '0;
    acc         = req_q & ready;

    // Compare first so that a start in the same cycle wins the clear.
    if (pv_q[RD_LAT-1] && (data_s2f_r != pe_q[RD_LAT-1])) begin
      if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      if (err_q == 16'd0) begin
        fail_addr_d = pa_q[RD_LAT-1];
        fail_data_d = data_s2f_r;
        fail_exp_d  = pe_q[RD_LAT-1];
      end
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StWr;
          phase_d     = 1'b0;
          cnt_d       = '0;
          err_d       = '0;
          fail_addr_d = '0;
          fail_data_d = '0;
          fail_exp_d  = '0;
        end
      end
      StWr: begin
        if (acc) begin
          if (cnt_q == LastAddr) begin
            cnt_d   = '0;
            state_d = StRd;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      StRd: begin
        if (acc) begin
          push = 1'b1;
          if (cnt_q == LastAddr) begin
            drain_d = '0;
            state_d = StDrain;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      StDrain: begin
        if (drain_q == DrainLast) begin
          if (!phase_q) begin
            phase_d = 1'b1;
            cnt_d   = '0;
            state_d = StWr;
          end else begin
            state_d = StDone;
          end
        end else begin
          drain_d = drain_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    pv_d[0] = push;
    pa_d[0] = cnt_q;
    pe_d[0] = pattern(cnt_q, phase_q);
    for (int i = 1; i < RD_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pa_d[i] = pa_q[i-1];
      pe_d[i] = pe_q[i-1];
    end

    // Request and status registers are loaded from the next state.
    req_d  = (state_d == StWr) || (state_d == StRd);
    rw_d   = (state_d != StWr);
    data_d = pattern(cnt_d, phase_d);
    busy_d = (state_d == StWr) || (state_d == StRd) || (state_d == StDrain);
    done_d = (state_d == StDone);
    pass_d = done_d && (err_d == 16'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      phase_q     <= 1'b0;
      cnt_q       <= '0;
      drain_q     <= '0;
      req_q       <= 1'b0;
      rw_q        <= 1'b1;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      fail_exp_q  <= '0;
      pv_q        <= '0;
      pa_q        <= '0;
      pe_q        <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      req_q       <= req_d;
      rw_q        <= rw_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      fail_exp_q  <= fail_exp_d;
      pv_q        <= pv_d;
      pa_q        <= pa_d;
      pe_q        <= pe_d;
    end
  end

  // A request is only valid in a cycle the controller can take it.
  assign mem       = req_q & ready;
  assign rw        = rw_q;
  assign addr      = cnt_q;
  assign data_f2s  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign fail_exp  = fail_exp_q;

endmodule

// File: tb/tb_sram_bist.sv
// Self-checking bench for sram_bist with a 16-word RAM model (2-cycle read latency)
// and per-address stuck-at masks.
module tb_sram_bist;
  localparam int unsigned AW = 18, DW = 16, LAST = 15, LAT = 2, N = LAST + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          ready = 1'b1;
  logic [DW-1:0] data_s2f_r;
  logic          mem, rw, busy, done, pass;
  logic [AW-1:0] addr, fail_addr;
  logic [DW-1:0] data_f2s, fail_data, fail_exp;
  logic [15:0]   err_cnt;

  sram_bist #(.ADDR_W(AW), .DATA_W(DW), .ADDR_LAST(LAST), .RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .mem(mem), .rw(rw), .addr(addr),
    .data_f2s(data_f2s), .ready(ready), .data_s2f_r(data_s2f_r), .busy(busy), .done(done),
    .pass(pass), .err_cnt(err_cnt), .fail_addr(fail_addr), .fail_data(fail_data),
    .fail_exp(fail_exp)
  );

  always #5 clk = ~clk;

  // RAM model: writes store, reads return stored data with stuck-at faults applied.
  logic [DW-1:0] ram [N];
  logic [DW-1:0] set_m [N];
  logic [DW-1:0] clr_m [N];
  logic [DW-1:0] rd_s1;
  logic          rst_s;
  always @(posedge clk) begin
    rst_s <= reset;
    if (mem && ready) begin
      if (rw) rd_s1 <= (ram[addr[3:0]] | set_m[addr[3:0]]) & ~clr_m[addr[3:0]];
      else    ram[addr[3:0]] <= data_f2s;
    end
    data_s2f_r <= rd_s1;
  end

  function automatic logic [15:0] pat(input int a, input bit ph);
    logic [15:0] p;
    p = 16'(a & 16'hFFFF) ^ 16'((a >> 16) & 3);
    return ph ? ~p : p;
  endfunction

  function automatic bit rdy_f(input int k, input bit s);
    return !(s && (k % 3 == 0));
  endfunction

  // Cycles the test must take: 2N accepted requests per phase plus LAT drain cycles.
  function automatic int exp_busy(input int k0, input bit s);
    int k = k0;
    for (int ph = 0; ph < 2; ph++) begin
      int got = 0;
      while (got < 2 * N) begin
        if (rdy_f(k, s)) got++;
        k++;
      end
      k += LAT;
    end
    return k - k0;
  endfunction

  int cyc = 0;
  bit stall_en = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    ready = rdy_f(cyc, stall_en);
  end

  // Stimulus-owned state
  int            epoch = 0;
  int            start_cyc = 0;
  bit            arm = 1'b0;
  bit            idle_chk = 1'b0;
  int            m_err;
  logic [AW-1:0] m_fa;
  logic [DW-1:0] m_fd, m_fe;
  bit            m_pass;
  bit            lit_en = 1'b0;
  int            lit_busy = 0;
  logic [15:0]   lit_err;
  logic [AW-1:0] lit_fa;
  logic [DW-1:0] lit_fd, lit_fe;
  bit            lit_pass;

  // Compare-process-owned state
  int total = 0, bad = 0;
  int ptr = 0, seen_epoch = 0, busy_len = 0, b0 = 0, fin_cnt = 0;
  bit busy_p = 1'b0, done_p = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (epoch != seen_epoch) begin
      seen_epoch = epoch;
      ptr = 0;
      busy_len = 0;
    end
    if (rst_s) begin
      chk("reset_req", {28'd0, mem, rw, addr, data_f2s}, {28'd0, 2'b01, 34'd0});
      chk("reset_status", {27'd0, busy, done, pass, err_cnt, fail_addr}, 64'd0);
      chk("reset_fail_data", {32'd0, fail_data, fail_exp}, 64'd0);
    end
    if (mem) begin
      if (!arm || ptr >= 4 * N) begin
        chk("unexpected_req", {63'd0, mem}, 64'd0);
      end else begin
        int ph, w, ea;
        bit er;
        ph = ptr / (2 * N);
        w  = ptr % (2 * N);
        er = (w >= N);
        ea = w % N;
        chk("req_ready", {63'd0, ready}, 64'd1);
        chk("req_fields", {29'd0, rw, addr, rw ? 16'd0 : data_f2s},
            {29'd0, er, 18'(ea), er ? 16'd0 : pat(ea, ph[0])});
        ptr++;
      end
    end
    if (arm) begin
      if (busy && !busy_p) begin
        b0 = cyc;
        chk("start_latency", 64'(b0), 64'(start_cyc + 1));
        chk("start_clears", {27'd0, done, pass, err_cnt, fail_addr}, 64'd0);
      end
      if (busy) busy_len++;
      if (done && !done_p) begin
        chk("busy_len", 64'(busy_len), 64'(exp_busy(b0, stall_en)));
        chk("req_count", 64'(ptr), 64'(4 * N));
        chk("status", {46'd0, done, pass, err_cnt}, {46'd0, 1'b1, m_pass, 16'(m_err)});
        chk("fail_regs", {14'd0, fail_addr, fail_data, fail_exp}, {14'd0, m_fa, m_fd, m_fe});
        if (lit_en) begin
          chk("lit_err_pass", {47'd0, pass, err_cnt}, {47'd0, lit_pass, lit_err});
          chk("lit_fail", {14'd0, fail_addr, fail_data, fail_exp}, {14'd0, lit_fa, lit_fd, lit_fe});
          if (lit_busy > 0) chk("lit_busy", 64'(busy_len), 64'(lit_busy));
        end
        fin_cnt++;
      end
    end
    if (idle_chk) chk("idle_quiet", {44'd0, mem, busy, done, pass, err_cnt}, 64'd0);
    busy_p = busy;
    done_p = done;
  end

  task automatic clear_faults();
    for (int a = 0; a < N; a++) begin
      set_m[a] = '0;
      clr_m[a] = '0;
    end
  endtask

  task automatic build_model();
    m_err = 0; m_fa = '0; m_fd = '0; m_fe = '0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int a = 0; a < N; a++) begin
        logic [15:0] e, r;
        e = pat(a, ph[0]);
        r = (e | set_m[a]) & ~clr_m[a];
        if (r != e) begin
          if (m_err == 0) begin
            m_fa = 18'(a); m_fd = r; m_fe = e;
          end
          if (m_err < 65535) m_err++;
        end
      end
    end
    m_pass = (m_err == 0);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #2;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic run_test(input bit stall, input bit dbl);
    int f0;
    stall_en = stall;
    build_model();
    f0 = fin_cnt;
    epoch++;
    arm = 1'b1;
    pulse_start();
    if (dbl) begin
      repeat (15) @(posedge clk);
      #2 start = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
    end
    for (int i = 0; i < 3000 && fin_cnt == f0; i++) @(posedge clk);
    if (fin_cnt == f0) begin
      $display("FAIL done_timeout: got done=%0b required done=1", done);
      $fatal(1, "test did not complete");
    end
    arm = 1'b0;
    lit_en = 1'b0;
    lit_busy = 0;
    stall_en = 1'b0;
  endtask

  task automatic set_lit(input logic [15:0] e, input bit p, input logic [AW-1:0] fa,
                         input logic [DW-1:0] fd, input logic [DW-1:0] fe, input int bl);
    lit_en = 1'b1; lit_err = e; lit_pass = p; lit_fa = fa; lit_fd = fd; lit_fe = fe;
    lit_busy = bl;
  endtask

  initial begin
    clear_faults();
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Clean RAM, ready always high
    set_lit(16'd0, 1'b1, 18'd0, 16'h0000, 16'h0000, 68);
    run_test(1'b0, 1'b0);

    // Bit 3 stuck-at-1 at address 5: only phase 0 sees it
    set_m[5] = 16'h0008;
    set_lit(16'd1, 1'b0, 18'd5, 16'h000D, 16'h0005, 68);
    run_test(1'b0, 1'b0);

    // Bit 15 stuck-at-1 everywhere: every phase-0 read fails, first capture holds address 0
    clear_faults();
    for (int a = 0; a < N; a++) set_m[a] = 16'h8000;
    set_lit(16'd16, 1'b0, 18'd0, 16'h8000, 16'h0000, 68);
    run_test(1'b0, 1'b0);

    // Stalls every third cycle plus a start pulse while busy
    clear_faults();
    set_lit(16'd0, 1'b1, 18'd0, 16'h0000, 16'h0000, 0);
    run_test(1'b1, 1'b1);

    // Immediate restart from done
    run_test(1'b0, 1'b0);

    // Start coinciding with reset is dropped
    @(posedge clk);
    #2 reset = 1'b1; start = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0; start = 1'b0; idle_chk = 1'b1;
    repeat (4) @(posedge clk);
    #2 idle_chk = 1'b0;

    // Reset during RD1 with phase-1 faults: pending compares must not count
    for (int a = 0; a < N; a++) clr_m[a] = 16'h8000;
    epoch++;
    arm = 1'b1;
    pulse_start();
    for (int i = 0; i < 500 && ptr < 3 * N + 4; i++) @(posedge clk);
    if (ptr < 3 * N + 4) begin
      $display("FAIL reach_rd1: got ptr=%0d required %0d", ptr, 3 * N + 4);
      $fatal(1, "phase 1 read not reached");
    end
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0; arm = 1'b0; idle_chk = 1'b1;
    repeat (6) @(posedge clk);
    #2 idle_chk = 1'b0;
    clear_faults();
    set_lit(16'd0, 1'b1, 18'd0, 16'h0000, 16'h0000, 68);
    run_test(1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_bist.md
# sram_bist

Built-in self-test sequencer that sits directly upstream of the SRAM controller. It drives the controller's `mem`/`rw`/`addr`/`data_f2s` request port and consumes `ready`/`data_s2f_r`. On `start` it writes an address-derived pattern over the whole address range, reads it back and compares, then repeats with the inverted pattern. It reports pass/fail, an error count and the first failing location.

## Interface
Parameters:
- `ADDR_W`, 18: controller address width.
- `DATA_W`, 16: controller data width.
- `ADDR_LAST`, 2**18-1: last address tested; the range is 0..`ADDR_LAST`. N = `ADDR_LAST`+1.
- `RD_LAT`, 2: cycles from the read issue cycle to the cycle in which `data_s2f_r` holds that read's data.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a test; ignored while `busy`=1.
- `mem`  out  1  request valid to the controller.
- `rw`  out  1  1 = read, 0 = write.
- `addr`  out  `ADDR_W`  request address.
- `data_f2s`  out  `DATA_W`  write data.
- `ready`  in  1  controller accepts a request this cycle.
- `data_s2f_r`  in  `DATA_W`  registered read data from the controller.
- `busy`  out  1  test in progress.
- `done`  out  1  test complete; held until the next accepted `start` or `reset`.
- `pass`  out  1  `done` & (`err_cnt`==0).
- `err_cnt`  out  16  mismatch count, saturating at 16'hFFFF.
- `fail_addr`  out  `ADDR_W`  address of the first mismatch.
- `fail_data`  out  `DATA_W`  data read at the first mismatch.
- `fail_exp`  out  `DATA_W`  expected data at the first mismatch.

## Operation
- Pattern: P(a) = a[15:0] ^ {14'b0, a[17:16]}, zero-extended or truncated to `DATA_W`. Phase 0 uses P(a); phase 1 uses ~P(a).
- States: IDLE, WR, RD, DRAIN, DONE. A phase bit (0/1) qualifies WR, RD and DRAIN.
- IDLE: `mem`=0. On `start`, clear `err_cnt` and the fail registers, clear `done`, set phase=0, address counter=0, and go to WR.
- WR: each cycle with `ready`=1, drive `mem`=1, `rw`=0, `addr`=cnt, `data_f2s`=pattern(cnt), then increment cnt. When `ready`=0, drive `mem`=0 and hold cnt. After the request at cnt=`ADDR_LAST` is accepted, set cnt=0 and go to RD.
- RD: same handshake with `rw`=1, `data_f2s` don't-care. Each accepted read pushes {valid, addr, expected} into an `RD_LAT`-deep shift pipe. The pipe advances every cycle, and non-read cycles push valid=0. After the read at `ADDR_LAST` is accepted, go to DRAIN.
- DRAIN: `mem`=0 for exactly `RD_LAT` cycles so all pending compares retire. Then, if phase=0: phase=1, cnt=0, go to WR. If phase=1: go to DONE.
- Compare: when the pipe output is valid, compare `data_s2f_r` with expected. On mismatch, increment `err_cnt` (saturating). If this is the first mismatch since `start`, capture `fail_addr`, `fail_data` and `fail_exp`.
- DONE: `done`=1, `busy`=0, `mem`=0. A `start` here restarts the test exactly as from IDLE.
- Address counter arithmetic is `ADDR_W` bits, with no wrap past `ADDR_LAST`.

## Timing
- Reset values: `mem`=0, `rw`=1, `addr`=0, `data_f2s`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_*`=0, state IDLE, shift pipe cleared.
- `reset` asserted mid-test aborts on the next edge: all values return to reset values, no further requests are issued, and pending compares are discarded.
- All request outputs and status outputs are registered.
  - `busy`=1 from the cycle after `start` is sampled through the last DRAIN cycle.
  - `done` rises the cycle after the final DRAIN cycle.
- With `ready` constantly 1, `busy` lasts exactly 2·(2N+`RD_LAT`) cycles.
- The first write request is presented the cycle after `start`.
- Back-to-back requests: one per cycle, with no bubble at the WR→RD transition.
- A `start` arriving in the same cycle as `reset` is ignored.
- A `start` while `busy` has no effect.
- Final-compare boundary: the read of `ADDR_LAST` is compared in the last DRAIN cycle of its phase.

## Test plan
- Clean RAM model (`RD_LAT`=2, `ADDR_LAST`=15, `ready`=1), pulse `start` → 32 writes and 32 reads in the order WR0, RD0, WR1, RD1; `busy` high for 68 cycles; `done`=1, `pass`=1, `err_cnt`=0.
- Model with data bit 3 stuck-at-1 at address 5, same setup → `err_cnt`=1 (phase 0 only, since ~P(5) already has bit 3 set); `fail_addr`=5, `fail_exp`=16'h0005, `fail_data`=16'h000D; `pass`=0.
- Model with 16 stuck-at faults (one on every address) → `err_cnt`=16 or more, and `fail_*` reflect address 0 only (first-capture holds).
- Toggle `ready` to 0 on every third cycle → `mem`=0 on stalled cycles, no address skipped or repeated, test still passes, and `busy` is lengthened by the number of stall cycles.
- Assert `reset` for one cycle during RD1, then pulse `start` → outputs return to reset values immediately; the new test runs cleanly from address 0 and passes.
- Pulse `start` again while `busy` and again after `done` → the first pulse is ignored; the second clears `done`/`err_cnt` and reruns the test.
